// File: rtl/nts_engine_pkg.sv
// Shared definitions for the NTS engine controller: FSM state codes,
// statistics counter width and a saturating increment helper.
package nts_engine_pkg;

    localparam int CNT_WIDTH = 32;

    // State codes are visible on o_state, so their values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE         = 4'h1,
        ST_COPY         = 4'h2,
        ST_DRAIN        = 4'h3,
        ST_PROCESS      = 4'h4,
        ST_DISCARD      = 4'h5,
        ST_ERR_OVERFLOW = 4'hD,
        ST_ERR_TIMEOUT  = 4'hE
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/nts_timeout_counter.sv
// Processing timeout counter. Counts cycles while enabled and flags the
// cycle that completes i_limit cycles; a zero limit never expires.
module nts_timeout_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   elapsed;

    // Cycle counter: cleared outside the timed window, counts inside it.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!i_reset_n || i_clear) begin
            count_q <= '0;
        end else if (i_enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds the cycles already spent; the current cycle is number
    // count_q+1, so the owner leaves its state exactly i_limit cycles after entry.
    assign elapsed   = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    assign o_expired = i_enable && (i_limit != '0) && (elapsed == {1'b0, i_limit});

endmodule

// File: rtl/nts_engine_ctrl.sv
// NTS engine controller: copies one packet from the dispatch FIFO into the
// packet buffer, starts downstream processing, waits for completion or a
// timeout, then releases the packet back to the dispatcher.
// Optional statistics counters are built when NTS_ENGINE_STATS_EN is defined;
// otherwise the counter ports are tied to zero.
module nts_engine_ctrl
    import nts_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 10,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout_cycles,
    input  logic                     i_dispatch_packet_available,
    input  logic                     i_dispatch_fifo_empty,
    output logic                     o_dispatch_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]    i_dispatch_fifo_rd_data,
    input  logic [DATA_WIDTH/8-1:0]  i_dispatch_data_valid,
    output logic                     o_dispatch_packet_read_discard,
    output logic                     o_buf_wr_en,
    output logic [ADDR_WIDTH-1:0]    o_buf_wr_addr,
    output logic [DATA_WIDTH-1:0]    o_buf_wr_data,
    output logic                     o_proc_start,
    output logic [ADDR_WIDTH:0]      o_proc_words,
    output logic [DATA_WIDTH/8-1:0]  o_proc_last_valid,
    input  logic                     i_proc_done,
    input  logic                     i_proc_error,
    output logic                     o_busy,
    output logic [3:0]               o_state,
    output logic [CNT_WIDTH-1:0]     o_cnt_ok,
    output logic [CNT_WIDTH-1:0]     o_cnt_overflow,
    output logic [CNT_WIDTH-1:0]     o_cnt_timeout,
    output logic [CNT_WIDTH-1:0]     o_cnt_proc_err
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH:0]       word_cnt_q, word_cnt_d;
    logic                      rd_en;
    logic                      enter_proc;
    logic                      wr_en_q;
    logic [ADDR_WIDTH-1:0]     wr_addr_q;
    logic                      proc_start_q;
    logic [ADDR_WIDTH:0]       proc_words_q;
    logic [DATA_WIDTH/8-1:0]   last_valid_q;
    logic                      tmo_expired;

    nts_timeout_counter #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (state_q != ST_PROCESS),
        .i_enable  (state_q == ST_PROCESS),
        .i_limit   (i_timeout_cycles),
        .o_expired (tmo_expired)
    );

    // Next-state, pop request and word counting.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        rd_en      = 1'b0;
        enter_proc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                word_cnt_d = '0;
                if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY: begin
                rd_en = !i_dispatch_fifo_empty && (word_cnt_q < DEPTH);
                if (rd_en) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
                if (i_dispatch_fifo_empty) begin
                    state_d = ST_DRAIN;
                end else if (word_cnt_q == DEPTH) begin
                    state_d = ST_ERR_OVERFLOW;
                end
            end
            ST_DRAIN: begin
                // One cycle for the last popped word to land in the buffer.
                state_d    = ST_PROCESS;
                enter_proc = 1'b1;
            end
            ST_PROCESS: begin
                // Completion takes priority over a simultaneous timeout.
                if (i_proc_done) begin
                    state_d = ST_DISCARD;
                end else if (tmo_expired) begin
                    state_d = ST_ERR_TIMEOUT;
                end
            end
            ST_DISCARD, ST_ERR_OVERFLOW, ST_ERR_TIMEOUT: begin
                word_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, buffer write pipeline and processing descriptor registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            proc_start_q <= 1'b0;
            proc_words_q <= '0;
            last_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            wr_en_q      <= rd_en;
            proc_start_q <= enter_proc;
            if (rd_en) begin
                wr_addr_q <= word_cnt_q[ADDR_WIDTH-1:0];
            end
            if (enter_proc) begin
                proc_words_q <= word_cnt_q;
                last_valid_q <= i_dispatch_data_valid;
            end
        end
    end

    // Popped data arrives one cycle after rd_en, aligned with wr_en_q.
    assign o_dispatch_fifo_rd_en          = rd_en && i_reset_n;
    assign o_buf_wr_en                    = wr_en_q;
    assign o_buf_wr_addr                  = wr_addr_q;
    assign o_buf_wr_data                  = wr_en_q ? i_dispatch_fifo_rd_data : '0;
    assign o_proc_start                   = proc_start_q;
    assign o_proc_words                   = proc_words_q;
    assign o_proc_last_valid              = last_valid_q;
    assign o_dispatch_packet_read_discard = (state_q == ST_DISCARD) ||
                                            (state_q == ST_ERR_OVERFLOW) ||
                                            (state_q == ST_ERR_TIMEOUT);
    assign o_busy                         = (state_q != ST_IDLE);
    assign o_state                        = state_q;

`ifdef NTS_ENGINE_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_ok_q, cnt_overflow_q, cnt_timeout_q, cnt_proc_err_q;
    logic                 done_seen;

    assign done_seen = (state_q == ST_PROCESS) && i_proc_done;

    // Saturating event counters; each error state lasts exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cnt_ok_q       <= '0;
            cnt_overflow_q <= '0;
            cnt_timeout_q  <= '0;
            cnt_proc_err_q <= '0;
        end else begin
            if (done_seen && !i_proc_error) cnt_ok_q       <= sat_inc(cnt_ok_q);
            if (done_seen && i_proc_error)  cnt_proc_err_q <= sat_inc(cnt_proc_err_q);
            if (state_q == ST_ERR_OVERFLOW) cnt_overflow_q <= sat_inc(cnt_overflow_q);
            if (state_q == ST_ERR_TIMEOUT)  cnt_timeout_q  <= sat_inc(cnt_timeout_q);
        end
    end

    assign o_cnt_ok       = cnt_ok_q;
    assign o_cnt_overflow = cnt_overflow_q;
    assign o_cnt_timeout  = cnt_timeout_q;
    assign o_cnt_proc_err = cnt_proc_err_q;
`else
    // The error flag only feeds the statistics; without them it is unused.
    logic unused_proc_error;
    assign unused_proc_error = i_proc_error;

    assign o_cnt_ok       = '0;
    assign o_cnt_overflow = '0;
    assign o_cnt_timeout  = '0;
    assign o_cnt_proc_err = '0;
`endif

endmodule

// File: tb/tb_nts_engine_ctrl.sv
// Scoreboard bench for nts_engine_ctrl (ADDR_WIDTH=2, buffer depth 4).
// Stimulus pushes expected buffer writes, processing starts and discard
// events into queues; a monitor pops and compares whenever the DUT shows one.
module tb_nts_engine_ctrl;

    localparam int DW = 64;
    localparam int AW = 2;
    localparam int TW = 16;
    localparam int KW = DW / 8;

`ifdef NTS_ENGINE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
    typedef struct packed { logic [AW:0] words; logic [KW-1:0] mask; } proc_exp_t;
    typedef struct packed { logic [3:0] state; int delay; } disc_exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [TW-1:0]   timeout_cycles;
    logic            pkt_avail;
    logic            fifo_empty;
    logic            rd_en;
    logic [DW-1:0]   rd_data = '0;
    logic [KW-1:0]   data_valid;
    logic            discard;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            proc_start;
    logic [AW:0]     proc_words;
    logic [KW-1:0]   proc_last_valid;
    logic            proc_done;
    logic            proc_error;
    logic            busy;
    logic [3:0]      state;
    logic [31:0]     cnt_ok, cnt_overflow, cnt_timeout, cnt_proc_err;

    // Dispatch FIFO model.
    logic [DW-1:0]   fifo_mem [0:127];
    logic [6:0]      rd_ptr = '0;
    logic [6:0]      wr_ptr = '0;
    logic            flush_req = 1'b0;

    wr_exp_t   exp_wr   [$];
    proc_exp_t exp_proc [$];
    disc_exp_t exp_disc [$];

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;
    int start_cycle = 0;
    int exp_ok = 0, exp_ovf = 0, exp_to = 0, exp_perr = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en) begin
            rd_data <= fifo_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
        end
    end

    nts_engine_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .i_clk                          (clk),
        .i_reset_n                      (reset_n),
        .i_timeout_cycles               (timeout_cycles),
        .i_dispatch_packet_available    (pkt_avail),
        .i_dispatch_fifo_empty          (fifo_empty),
        .o_dispatch_fifo_rd_en          (rd_en),
        .i_dispatch_fifo_rd_data        (rd_data),
        .i_dispatch_data_valid          (data_valid),
        .o_dispatch_packet_read_discard (discard),
        .o_buf_wr_en                    (wr_en),
        .o_buf_wr_addr                  (wr_addr),
        .o_buf_wr_data                  (wr_data),
        .o_proc_start                   (proc_start),
        .o_proc_words                   (proc_words),
        .o_proc_last_valid              (proc_last_valid),
        .i_proc_done                    (proc_done),
        .i_proc_error                   (proc_error),
        .o_busy                         (busy),
        .o_state                        (state),
        .o_cnt_ok                       (cnt_ok),
        .o_cnt_overflow                 (cnt_overflow),
        .o_cnt_timeout                  (cnt_timeout),
        .o_cnt_proc_err                 (cnt_proc_err)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: DUT event with nothing expected (t=%0t)", name, $time);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        wr_exp_t   we;
        proc_exp_t pe;
        disc_exp_t de;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (wr_en === 1'b1) begin
                if (exp_wr.size() == 0) unexpected("buf_write");
                else begin
                    we = exp_wr.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(we.addr));
                    check("wr_data", wr_data, we.data);
                end
            end
            if (proc_start === 1'b1) begin
                start_cycle = cycle;
                if (exp_proc.size() == 0) unexpected("proc_start");
                else begin
                    pe = exp_proc.pop_front();
                    check("proc_words", 64'(proc_words), 64'(pe.words));
                    check("proc_last_valid", 64'(proc_last_valid), 64'(pe.mask));
                end
            end
            if (discard === 1'b1) begin
                if (exp_disc.size() == 0) unexpected("discard");
                else begin
                    de = exp_disc.pop_front();
                    check("discard_state", 64'(state), 64'(de.state));
                    if (de.delay >= 0) check("discard_delay", 64'(cycle - start_cycle), 64'(de.delay));
                end
            end
        end
    end

    // Load n words into the FIFO, expect the first n_wr of them in the buffer.
    task automatic start_packet(input int n, input int n_wr, input logic [KW-1:0] mask,
                                input logic [TW-1:0] tmo, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = base + DW'(i);
            if (i < n_wr) exp_wr.push_back('{addr: AW'(i), data: base + DW'(i)});
            wr_ptr = wr_ptr + 1'b1;
        end
        data_valid     = mask;
        timeout_cycles = tmo;
        pkt_avail      = 1'b1;
    endtask

    task automatic wait_proc_start();
        int budget = 50;
        while (proc_start !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("proc_start_seen", 64'(proc_start === 1'b1), 64'd1);
    endtask

    task automatic pulse_done_after(input int k, input logic err);
        repeat (k) @(negedge clk);
        proc_done  = 1'b1;
        proc_error = err;
        @(negedge clk);
        proc_done  = 1'b0;
        proc_error = 1'b0;
    endtask

    // Wait for the release pulse, then withdraw the packet and drop leftovers.
    task automatic wait_discard();
        int budget = 2000;
        while (discard !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("discard_seen", 64'(discard === 1'b1), 64'd1);
        pkt_avail = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cnt_ok"},       64'(cnt_ok),       STATS_EN ? 64'(exp_ok)   : 64'd0);
        check({tag, "_cnt_overflow"}, 64'(cnt_overflow), STATS_EN ? 64'(exp_ovf)  : 64'd0);
        check({tag, "_cnt_timeout"},  64'(cnt_timeout),  STATS_EN ? 64'(exp_to)   : 64'd0);
        check({tag, "_cnt_proc_err"}, 64'(cnt_proc_err), STATS_EN ? 64'(exp_perr) : 64'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        timeout_cycles = '0;
        pkt_avail      = 1'b0;
        data_valid     = '0;
        proc_done      = 1'b0;
        proc_error     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_state", 64'(state), 64'h1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_discard", 64'(discard), 64'd0);
        check("rst_proc_start", 64'(proc_start), 64'd0);
        check("rst_proc_words", 64'(proc_words), 64'd0);
        check_counters("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Packet available with an empty FIFO; a stray done is ignored.
        pkt_avail = 1'b1;
        for (int i = 0; i < 20; i++) begin
            proc_done = (i == 5);
            @(negedge clk);
            check("idle_state", 64'(state), 64'h1);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_rd_en", 64'(rd_en), 64'd0);
        end
        proc_done = 1'b0;
        pkt_avail = 1'b0;
        @(negedge clk);

        // 3-word packet, done 5 cycles after start.
        start_packet(3, 3, 8'h0F, 16'd100, 64'hA5A5_0000_0000_1000);
        exp_proc.push_back('{words: 3'd3, mask: 8'h0F});
        exp_disc.push_back('{state: 4'h5, delay: 6});
        wait_proc_start();
        pulse_done_after(5, 1'b0);
        exp_ok++;
        wait_discard();
        check_counters("pkt3");

        // 5-word packet overflows a 4-word buffer after 4 pops.
        start_packet(5, 4, 8'hFF, 16'd100, 64'h1234_5678_0000_2000);
        exp_disc.push_back('{state: 4'hD, delay: -1});
        wait_discard();
        exp_ovf++;
        check_counters("ovf");

        // Exactly 4 words fits.
        start_packet(4, 4, 8'h01, 16'd100, 64'hDEAD_BEEF_0000_3000);
        exp_proc.push_back('{words: 3'd4, mask: 8'h01});
        exp_disc.push_back('{state: 4'h5, delay: 3});
        wait_proc_start();
        pulse_done_after(2, 1'b0);
        exp_ok++;
        wait_discard();
        check_counters("pkt4");

        // Timeout 10 with no done.
        start_packet(1, 1, 8'h80, 16'd10, 64'h0F0F_0F0F_0000_4000);
        exp_proc.push_back('{words: 3'd1, mask: 8'h80});
        exp_disc.push_back('{state: 4'hE, delay: 10});
        wait_proc_start();
        wait_discard();
        exp_to++;
        check_counters("tmo");

        // Done (with error) in the cycle the timeout expires: done wins.
        start_packet(2, 2, 8'h3F, 16'd10, 64'h7777_0000_0000_5000);
        exp_proc.push_back('{words: 3'd2, mask: 8'h3F});
        exp_disc.push_back('{state: 4'h5, delay: 10});
        wait_proc_start();
        pulse_done_after(9, 1'b1);
        exp_perr++;
        wait_discard();
        check_counters("race");

        // Timeout 0: no expiry within 1000 cycles.
        start_packet(1, 1, 8'h07, 16'd0, 64'h0000_0001_0000_6000);
        exp_proc.push_back('{words: 3'd1, mask: 8'h07});
        exp_disc.push_back('{state: 4'h5, delay: 1001});
        wait_proc_start();
        repeat (1000) @(negedge clk);
        check("tmo0_state", 64'(state), 64'h4);
        pulse_done_after(0, 1'b0);
        exp_ok++;
        wait_discard();

        // Reset while the second word is being popped.
        start_packet(4, 1, 8'hFF, 16'd100, 64'hCAFE_0000_0000_7000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rstmid_rd_en_comb", 64'(rd_en), 64'd0);
        @(negedge clk);
        exp_ok = 0; exp_ovf = 0; exp_to = 0; exp_perr = 0;
        check("rstmid_state", 64'(state), 64'h1);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_wr_en", 64'(wr_en), 64'd0);
        check("rstmid_wr_addr", 64'(wr_addr), 64'd0);
        check("rstmid_wr_data", wr_data, 64'd0);
        check("rstmid_discard", 64'(discard), 64'd0);
        check("rstmid_proc_words", 64'(proc_words), 64'd0);
        check("rstmid_last_valid", 64'(proc_last_valid), 64'd0);
        check_counters("rstmid");
        reset_n   = 1'b1;
        pkt_avail = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);

        // Next packet restarts from address 0.
        start_packet(2, 2, 8'h03, 16'd100, 64'hBEEF_0000_0000_8000);
        exp_proc.push_back('{words: 3'd2, mask: 8'h03});
        exp_disc.push_back('{state: 4'h5, delay: 2});
        wait_proc_start();
        pulse_done_after(1, 1'b0);
        exp_ok++;
        wait_discard();
        check_counters("post");

        repeat (3) @(negedge clk);
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_starts", 64'(exp_proc.size()), 64'd0);
        check("pending_discards", 64'(exp_disc.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog in case a wait loop is broken.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
